mips32_pipe_core: RTL and testbench
===================================

// Module: mips32_pipe_core
// PURPOSE
//  Parametrised single-clock 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset core; successor to the two-phase pipeline.
//  Adds hazard interlock, operand forwarding, branch flush, sync reset and external instruction/data memory ports.
//  Same opcode set and 32-bit instruction format. Sits between testbench/SoC memories and the debug/trace bench.
// PARAMETERS
//  DATA_W    32     datapath/register width (32 or 64); immediates sign-extended to DATA_W
//  ADDR_W    10     word-address width of imem/dmem
//  RESET_PC  0      PC value loaded on reset
// PORTS
//  clk1         in   1        single core clock, all state on posedge
//  rst          in   1        synchronous, active-high reset
//  imem_addr    out  ADDR_W   fetch address (= PC)
//  imem_rdata   in   32       instruction, combinational from imem_addr
//  dmem_addr    out  ADDR_W   MEM-stage address (ALU result [ADDR_W-1:0])
//  dmem_wdata   out  DATA_W   store data
//  dmem_we      out  1        store strobe, one cycle per committed SW
//  dmem_rdata   in   DATA_W   load data, combinational from dmem_addr
//  dbg_raddr    in   5        debug register index
//  dbg_rdata    out  DATA_W   Reg[dbg_raddr], combinational
//  halted       out  1        sticky, HLT reached WB
//  illegal      out  1        sticky, undefined opcode reached WB
//  retire_cnt   out  32       non-bubble instructions retired in WB, saturating
// BEHAVIOUR
//  - Reset: PC=RESET_PC, all stage valid bits 0 (bubbles), Reg[0..31]=0, halted=0, illegal=0, retire_cnt=0, dmem_we=0.
//  - Opcodes: ADD 000000 SUB 000001 AND 000010 OR 000011 SLT 000100 MUL 000101 LW 001000 SW 001001
//    ADDI 001010 SUBI 001011 SLTI 001100 BNEQZ 001101 BEQZ 001110 HLT 111111; rs=[25:21] rt=[20:16] rd=[15:11] imm=[15:0].
//  - RR ops write rd; ADDI/SUBI/SLTI/LW write rt. Writes to r0 dropped; r0 always reads 0.
//  - SLT/SLTI signed compare, result 1/0. MUL keeps low DATA_W bits. Wrap-around on add/sub.
//  - LW/SW address = A + imm (word address, truncated to ADDR_W). SW writes B in MEM stage.
//  - Reg file write-through: ID reading a reg written in WB the same cycle sees the new value.
//  - Branch resolved in EX: BEQZ taken iff A==0, BNEQZ taken iff A!=0; target = NPC + imm (NPC = branch PC+1).
//    Taken: PC<=target, IF/ID and ID/EX squashed -> 2-cycle penalty. Not taken: no penalty.
//  - Load-use: ID consumer of LW dest in EX stalls 1 cycle (PC, IF/ID hold; bubble into EX).
//  - HLT decoded in ID: fetch frozen, bubbles issued; older instrs drain; halted=1 when HLT in WB; all state frozen until rst.
//  - Undefined opcode: executes as HLT and additionally sets illegal.
//  - Stall and taken-branch same cycle: branch wins (stalled instr is younger, squashed).
//  - rst mid-operation: in-flight instrs discarded, no dmem_we in reset cycle; dmem contents untouched.
//  - Squashed SW never asserts dmem_we; squashed/bubble slots never write regs or count in retire_cnt.
// CONFIGURATION
//  FORWARDING_EN defined: EX operands bypassed from EX/MEM (ALU result) over MEM/WB (ALU or load data);
//    only load-use stalls (1 cycle).
//  FORWARDING_EN undefined: no bypass; ID stalls while EX or MEM holds a pending write to rs/rt
//    (up to 2 stall cycles; WB covered by write-through).
// TESTING
//  1 ADDI r1,r0,10; ADDI r2,r0,20; ADD r3,r1,r2; HLT -> r3=30, halted=1, retire_cnt=4; without FORWARDING_EN halted rises exactly 2 cycles later.
//  2 dmem[5]=0x55; LW r4,5(r0); ADD r5,r4,r4; HLT -> r5=0xAA, exactly 1 stall cycle with FORWARDING_EN, 2 without.
//  3 BEQZ r0,+2; ADDI r6,r0,1; ADDI r7,r0,1; ADDI r8,r0,3; HLT -> r6=0, r7=0, r8=3, retire_cnt=3.
//  4 r1=3 countdown loop (SUBI r1,r1,1; BNEQZ r1,-2), then SW r1,100(r0) -> loop body retires 3x, dmem[100]=0, one dmem_we pulse.
//  5 assert rst for 1 cycle mid-program of test 1 after ADD fetched -> all regs 0, retire_cnt=0, restart from RESET_PC yields r3=30.
//  6 opcode 6'b010101 followed by ADDI r1,r0,5 -> illegal=1, halted=1, r1=0.

Source files
------------

// File: rtl/mips32_pipe_core.sv
// mips32_pipe_core: single-clock 5-stage MIPS32-subset pipeline with interlock.
// Define FORWARDING_EN to enable the EX operand bypass.
module mips32_pipe_core #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0
) (
  input  logic              clk1,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       retire_cnt
);

  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef struct packed {
    logic              v;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dst;
    logic              we;
    logic              lw;
    logic              sw;
    logic              hlt;
    logic              ill;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] npc;
  } id_ex_t;

  typedef struct packed {
    logic              v;
    logic              we;
    logic              lw;
    logic              sw;
    logic              hlt;
    logic              ill;
    logic [4:0]        dst;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] b;
  } ex_mem_t;

  typedef struct packed {
    logic              v;
    logic              we;
    logic              hlt;
    logic              ill;
    logic [4:0]        dst;
    logic [DATA_W-1:0] val;
  } mem_wb_t;

  logic [DATA_W-1:0] regs [32];
  logic [ADDR_W-1:0] pc;
  logic              stop;
  logic              ifid_v;
  logic [31:0]       ifid_ir;
  logic [ADDR_W-1:0] ifid_npc;
  id_ex_t            idex;
  ex_mem_t           exmem;
  mem_wb_t           memwb;

  logic [5:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [DATA_W-1:0] imm;
  logic              use_rs;
  logic              use_rt;
  logic              wr;
  logic              wr_rt;
  logic              is_lw;
  logic              is_sw;
  logic              is_hlt;
  logic              is_ill;
  logic [4:0]        dst;
  logic              we;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              stall;
  logic [DATA_W-1:0] fa;
  logic [DATA_W-1:0] fb;
  logic [DATA_W-1:0] alu;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] mem_val;

  assign op  = ifid_ir[31:26];
  assign rs  = ifid_ir[25:21];
  assign rt  = ifid_ir[20:16];
  assign rd  = ifid_ir[15:11];
  assign imm = {{(DATA_W-16){ifid_ir[15]}}, ifid_ir[15:0]};

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    wr     = 1'b0;
    wr_rt  = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    is_hlt = 1'b0;
    is_ill = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        wr     = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_SLTI: begin
        use_rs = 1'b1;
        wr     = 1'b1;
        wr_rt  = 1'b1;
      end
      OP_LW: begin
        use_rs = 1'b1;
        wr     = 1'b1;
        wr_rt  = 1'b1;
        is_lw  = 1'b1;
      end
      OP_SW: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        is_sw  = 1'b1;
      end
      OP_BNEQZ, OP_BEQZ: use_rs = 1'b1;
      OP_HLT: is_hlt = 1'b1;
      default: begin
        is_hlt = 1'b1;
        is_ill = 1'b1;
      end
    endcase
  end

  assign dst = wr ? (wr_rt ? rt : rd) : 5'd0;
  assign we  = wr && (dst != 5'd0);

  // WB write-through: ID sees the value retiring this cycle
  always_comb begin
    rd_a = regs[rs];
    rd_b = regs[rt];
    if (memwb.v && memwb.we && memwb.dst == rs) rd_a = memwb.val;
    if (memwb.v && memwb.we && memwb.dst == rt) rd_b = memwb.val;
    if (rs == 5'd0) rd_a = '0;
    if (rt == 5'd0) rd_b = '0;
  end

`ifdef FORWARDING_EN
  assign stall = ifid_v && idex.v && idex.lw && idex.we &&
                 ((use_rs && idex.dst == rs) ||
                  (use_rt && idex.dst == rt));

  always_comb begin
    fa = idex.a;
    fb = idex.b;
    if (memwb.v && memwb.we && memwb.dst == idex.rs) fa = memwb.val;
    if (memwb.v && memwb.we && memwb.dst == idex.rt) fb = memwb.val;
    if (exmem.v && exmem.we && exmem.dst == idex.rs) fa = exmem.alu;
    if (exmem.v && exmem.we && exmem.dst == idex.rt) fb = exmem.alu;
  end
`else
  assign stall = ifid_v &&
                 ((idex.v && idex.we &&
                   ((use_rs && idex.dst == rs) ||
                    (use_rt && idex.dst == rt))) ||
                  (exmem.v && exmem.we &&
                   ((use_rs && exmem.dst == rs) ||
                    (use_rt && exmem.dst == rt))));

  assign fa = idex.a;
  assign fb = idex.b;
`endif

  always_comb begin
    alu = '0;
    case (idex.op)
      OP_ADD:  alu = fa + fb;
      OP_SUB:  alu = fa - fb;
      OP_AND:  alu = fa & fb;
      OP_OR:   alu = fa | fb;
      OP_SLT:  alu = {{(DATA_W-1){1'b0}}, $signed(fa) < $signed(fb)};
      OP_MUL:  alu = fa * fb;
      OP_ADDI, OP_LW, OP_SW: alu = fa + idex.imm;
      OP_SUBI: alu = fa - idex.imm;
      OP_SLTI: alu = {{(DATA_W-1){1'b0}}, $signed(fa) < $signed(idex.imm)};
      default: alu = '0;
    endcase
  end

  assign taken  = idex.v &&
                  ((idex.op == OP_BEQZ  && fa == '0) ||
                   (idex.op == OP_BNEQZ && fa != '0));
  assign target = idex.npc + idex.imm[ADDR_W-1:0];

  assign mem_val    = exmem.lw ? dmem_rdata : exmem.alu;
  assign imem_addr  = pc;
  assign dmem_addr  = exmem.alu[ADDR_W-1:0];
  assign dmem_wdata = exmem.b;
  assign dmem_we    = exmem.v && exmem.sw && !halted && !rst;
  assign dbg_rdata  = regs[dbg_raddr];

  always_ff @(posedge clk1) begin
    if (rst) begin
      pc         <= PC0;
      stop       <= 1'b0;
      ifid_v     <= 1'b0;
      ifid_ir    <= '0;
      ifid_npc   <= '0;
      idex       <= '0;
      exmem      <= '0;
      memwb      <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      retire_cnt <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!halted) begin
      if (memwb.v) begin
        if (memwb.we) regs[memwb.dst] <= memwb.val;
        if (retire_cnt != '1) retire_cnt <= retire_cnt + 32'd1;
        if (memwb.hlt) begin
          halted  <= 1'b1;
          illegal <= memwb.ill;
        end
      end

      memwb.v   <= exmem.v;
      memwb.we  <= exmem.we;
      memwb.hlt <= exmem.hlt;
      memwb.ill <= exmem.ill;
      memwb.dst <= exmem.dst;
      memwb.val <= mem_val;

      exmem.v   <= idex.v;
      exmem.we  <= idex.we;
      exmem.lw  <= idex.lw;
      exmem.sw  <= idex.sw;
      exmem.hlt <= idex.hlt;
      exmem.ill <= idex.ill;
      exmem.dst <= idex.dst;
      exmem.alu <= alu;
      exmem.b   <= fb;

      // a taken branch squashes the younger IF/ID and ID/EX slots
      if (taken) begin
        pc     <= target;
        ifid_v <= 1'b0;
        idex.v <= 1'b0;
      end else if (stall) begin
        idex.v <= 1'b0;
      end else begin
        idex.v   <= ifid_v;
        idex.op  <= op;
        idex.rs  <= rs;
        idex.rt  <= rt;
        idex.dst <= dst;
        idex.we  <= we;
        idex.lw  <= is_lw;
        idex.sw  <= is_sw;
        idex.hlt <= is_hlt;
        idex.ill <= is_ill;
        idex.a   <= rd_a;
        idex.b   <= rd_b;
        idex.imm <= imm;
        idex.npc <= ifid_npc;
        if (ifid_v && is_hlt) begin
          stop   <= 1'b1;
          ifid_v <= 1'b0;
        end else if (!stop) begin
          ifid_v   <= 1'b1;
          ifid_ir  <= imem_rdata;
          ifid_npc <= pc + ADDR_W'(1);
          pc       <= pc + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mips32_pipe_core.sv
// tb_mips32_pipe_core: directed programs with hand-computed results.
// Halt timing expectations follow the FORWARDING_EN setting.
module tb_mips32_pipe_core;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

`ifdef FORWARDING_EN
  localparam int T1 = 8;
  localparam int T2 = 8;
`else
  localparam int T1 = 10;
  localparam int T2 = 9;
`endif

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic [4:0]  dbg_raddr = 5'd0;
  logic [31:0] dbg_rdata;
  logic        halted;
  logic        illegal;
  logic [31:0] retire_cnt;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_a = '0;
  logic [31:0] ld_d = '0;
  int          we_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  mips32_pipe_core dut (
    .clk1       (clk1),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .halted     (halted),
    .illegal    (illegal),
    .retire_cnt (retire_cnt)
  );

  always #5 clk1 = ~clk1;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk1) begin
    if (ld_en) dmem[ld_a] <= ld_d;
    else if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    if (dmem_we) we_cnt <= we_cnt + 1;
  end

  function automatic logic [31:0] rr(input logic [5:0] o,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {o, s, t, d, 11'b0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] o,
      input logic [4:0] s, input logic [4:0] t, input logic [15:0] i);
    return {o, s, t, i};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk1);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
    @(negedge clk1);
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic rdreg(input logic [4:0] i, output logic [31:0] v);
    dbg_raddr = i;
    #1;
    v = dbg_rdata;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk1);
      #1;
      n++;
      if (halted === 1'b1) break;
    end
    chk("halt_reached", halted, 1);
    @(negedge clk1);
  endtask

  task automatic load_prog1();
    clear_imem();
    imem[0] = ri(OP_ADDI, 0, 1, 16'd10);
    imem[1] = ri(OP_ADDI, 0, 2, 16'd20);
    imem[2] = rr(OP_ADD, 1, 2, 3);
    imem[3] = {OP_HLT, 26'b0};
  endtask

  initial begin
    int n;
    int w0;
    logic [31:0] v;

    // reset state
    load_prog1();
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_pc", imem_addr, 0);
    chk("rst_we", dmem_we, 0);
    rdreg(5'd3, v);
    chk("rst_r3", v, 0);
    @(negedge clk1);
    rst = 1'b0;

    // 1: RAW chain through add
    wait_halt(n);
    chk("t1_cycles", n, T1);
    rdreg(5'd1, v); chk("t1_r1", v, 10);
    rdreg(5'd3, v); chk("t1_r3", v, 30);
    chk("t1_retire", retire_cnt, 4);
    chk("t1_illegal", illegal, 0);

    // 2: load-use
    preload(10'd5, 32'h55);
    clear_imem();
    imem[0] = ri(OP_LW, 0, 4, 16'd5);
    imem[1] = rr(OP_ADD, 4, 4, 5);
    imem[2] = {OP_HLT, 26'b0};
    do_reset();
    wait_halt(n);
    chk("t2_cycles", n, T2);
    rdreg(5'd4, v); chk("t2_r4", v, 32'h55);
    rdreg(5'd5, v); chk("t2_r5", v, 32'hAA);
    chk("t2_retire", retire_cnt, 3);

    // 3: taken branch squashes two slots
    clear_imem();
    imem[0] = ri(OP_BEQZ, 0, 0, 16'd2);
    imem[1] = ri(OP_ADDI, 0, 6, 16'd1);
    imem[2] = ri(OP_ADDI, 0, 7, 16'd1);
    imem[3] = ri(OP_ADDI, 0, 8, 16'd3);
    imem[4] = {OP_HLT, 26'b0};
    do_reset();
    wait_halt(n);
    rdreg(5'd6, v); chk("t3_r6", v, 0);
    rdreg(5'd7, v); chk("t3_r7", v, 0);
    rdreg(5'd8, v); chk("t3_r8", v, 3);
    chk("t3_retire", retire_cnt, 3);

    // 4: countdown loop then store
    preload(10'd100, 32'hDEAD);
    w0 = we_cnt;
    clear_imem();
    imem[0] = ri(OP_ADDI, 0, 1, 16'd3);
    imem[1] = ri(OP_SUBI, 1, 1, 16'd1);
    imem[2] = ri(OP_BNEQZ, 1, 0, 16'hFFFE);
    imem[3] = ri(OP_SW, 0, 1, 16'd100);
    imem[4] = {OP_HLT, 26'b0};
    do_reset();
    wait_halt(n);
    chk("t4_dmem100", dmem[100], 0);
    chk("t4_we_pulses", we_cnt - w0, 1);
    chk("t4_retire", retire_cnt, 9);
    rdreg(5'd1, v); chk("t4_r1", v, 0);

    // 5: reset mid-program
    load_prog1();
    do_reset();
    repeat (6) @(posedge clk1);
    @(negedge clk1);
    rdreg(5'd1, v); chk("t5_pre_r1", v, 10);
    chk("t5_pre_retire", retire_cnt, 2);
    rst = 1'b1;
    @(posedge clk1);
    #1;
    chk("t5_rst_we", dmem_we, 0);
    @(negedge clk1);
    rst = 1'b0;
    rdreg(5'd1, v); chk("t5_r1_clr", v, 0);
    rdreg(5'd2, v); chk("t5_r2_clr", v, 0);
    chk("t5_retire_clr", retire_cnt, 0);
    chk("t5_pc", imem_addr, 0);
    wait_halt(n);
    chk("t5_cycles", n, T1);
    rdreg(5'd3, v); chk("t5_r3", v, 30);
    chk("t5_retire", retire_cnt, 4);

    // 6: undefined opcode
    clear_imem();
    imem[0] = {6'b010101, 26'b0};
    imem[1] = ri(OP_ADDI, 0, 1, 16'd5);
    do_reset();
    wait_halt(n);
    chk("t6_illegal", illegal, 1);
    rdreg(5'd1, v); chk("t6_r1", v, 0);
    chk("t6_retire", retire_cnt, 1);
    repeat (3) @(posedge clk1);
    #1;
    chk("t6_frozen_pc", imem_addr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
